// File: rtl/mips_prog_loader.sv
// Boot loader: receives a framed byte stream, writes big-endian words to instruction
// memory from address 0, and releases the CPU once the frame checksum matches.
//
// state   | meaning
// IDLE    | waiting for sync byte 0xA5, all other bytes dropped
// LEN_HI  | next byte is N[15:8]
// LEN_LO  | next byte is N[7:0]; oversize N rejects, N=0 skips payload
// DATA    | assembling payload words, one write per 4 bytes
// CHK     | next byte is the XOR of all payload bytes
// DONE    | frame accepted, CPU released; 0xA5 starts a new frame
// ERROR   | frame rejected, CPU held; 0xA5 starts a new frame
module mips_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  state_t state, state_nxt;
  logic [15:0]       len;
  logic [15:0]       n_full;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        csum;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic              accept;
  logic              sync;
  logic              last_word;

  assign rx_ready  = !rst && !mem_we;
  assign accept    = rx_valid && rx_ready;
  assign n_full    = {len[15:8], rx_data};
  assign last_word = (word_count == len - 16'd1);
  assign sync      = accept && (rx_data == 8'hA5) &&
                     (state == S_IDLE || state == S_DONE || state == S_ERROR);

  assign cpu_hold = (state != S_DONE);
  assign busy     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHK);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);

  always_ff @(posedge clk1) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (rx_data == 8'hA5) state_nxt = S_LEN_HI;
        S_LEN_HI: state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if ({1'b0, n_full} > MAX_N) state_nxt = S_ERROR;
          else if (n_full == 16'd0)   state_nxt = S_CHK;
          else                        state_nxt = S_DATA;
        end
        S_DATA:   if (byte_cnt == 2'd3 && last_word) state_nxt = S_CHK;
        S_CHK:    state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      len        <= '0;
      addr_cnt   <= '0;
      csum       <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_start  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      if (sync) begin
        len        <= '0;
        addr_cnt   <= '0;
        csum       <= '0;
        byte_cnt   <= '0;
        word_count <= '0;
      end
      if (accept) begin
        case (state)
          S_LEN_HI: len[15:8] <= rx_data;
          S_LEN_LO: len[7:0]  <= rx_data;
          S_DATA: begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], rx_data};
            // fourth byte completes the word; write goes out next cycle
            if (byte_cnt == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= addr_cnt;
              mem_wdata  <= {shift, rx_data};
              addr_cnt   <= addr_cnt + ADDR_W'(1);
              word_count <= word_count + 16'd1;
            end
          end
          S_CHK:   cpu_start <= (rx_data == csum);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized bench for mips_prog_loader: frames are built at byte level, expected writes
// are queued from the frame contents and a monitor checks every memory write.
module tb_mips_prog_loader;
  localparam int AW = 4;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          cpu_start;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   word_count;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int exp_start = 0;
  bit gaps = 0;
  logic [AW+31:0] exp_q[$];
  logic [31:0]    words[$];

  always #5 clk1 = ~clk1;

  mips_prog_loader #(.ADDR_W(AW)) dut (
    .clk1(clk1), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy), .done(done),
    .err(err), .word_count(word_count)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // monitor: every write must match the head of the expected-write queue
  initial begin
    logic [AW+31:0] e;
    forever begin
      @(negedge clk1);
      #1;
      if (!rst) check("rx_ready_vs_we", 32'(rx_ready), 32'(!mem_we));
      if (cpu_start) start_cnt++;
      if (mem_we) begin
        if (exp_q.size() == 0) check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e[AW+31:32]));
          check("write_data", mem_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int k;
    ok = 0;
    if (gaps) begin
      k = $urandom_range(0, 3);
      repeat (k) @(negedge clk1);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = rx_ready;
      @(negedge clk1);
    end
    rx_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input int n, input logic [7:0] flip);
    logic [15:0] nn;
    logic [7:0]  x;
    logic [31:0] w;
    nn = 16'(n);
    x  = 8'h00;
    send_byte(8'hA5);
    check("busy_after_sync", 32'(busy), 1);
    check("hold_after_sync", 32'(cpu_hold), 1);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    if (n > (1 << AW)) begin
      check("err_oversize", 32'(err), 1);
      check("busy_oversize", 32'(busy), 0);
      check("hold_oversize", 32'(cpu_hold), 1);
      check("wc_oversize", 32'(word_count), 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = words[i];
      exp_q.push_back({AW'(i), w});
      for (int j = 3; j >= 0; j--) begin
        x ^= w[8*j +: 8];
        send_byte(w[8*j +: 8]);
      end
    end
    send_byte(x ^ flip);
    if (flip == 8'h00) begin
      exp_start++;
      check("done_release", 32'(done), 1);
      check("err_release", 32'(err), 0);
      check("hold_release", 32'(cpu_hold), 0);
      check("start_pulse", 32'(cpu_start), 1);
    end else begin
      check("err_reject", 32'(err), 1);
      check("done_reject", 32'(done), 0);
      check("hold_reject", 32'(cpu_hold), 1);
      check("start_reject", 32'(cpu_start), 0);
    end
    check("word_count", 32'(word_count), 32'(n));
    @(negedge clk1);
    check("start_one_cycle", 32'(cpu_start), 0);
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic load_nominal();
    words = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
              32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
  endtask

  task automatic load_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk1);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_hold", 32'(cpu_hold), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_start", 32'(cpu_start), 0);
    check("rst_wc", 32'(word_count), 0);
    rst = 1'b0;
    @(negedge clk1);
    check("idle_rx_ready", 32'(rx_ready), 1);

    // noise then empty frame
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("noise_busy", 32'(busy), 0);
    check("noise_hold", 32'(cpu_hold), 1);
    words.delete();
    send_frame(0, 8'h00);

    load_nominal();
    send_frame(9, 8'h00);
    send_frame(9, 8'h01);
    gaps = 1;
    send_frame(9, 8'h00);

    // oversize frame, trailing bytes ignored
    gaps = 0;
    send_frame(17, 8'h00);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    check("oversize_err_held", 32'(err), 1);
    check("oversize_busy", 32'(busy), 0);
    check("oversize_wc", 32'(word_count), 0);

    // largest legal frame
    load_random(1 << AW);
    gaps = 1;
    send_frame(1 << AW, 8'h00);
    load_random(3);
    send_frame(3, 8'h5C);

    // reset after two of nine words
    gaps = 0;
    load_nominal();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h09);
    exp_q.push_back({AW'(0), words[0]});
    exp_q.push_back({AW'(1), words[1]});
    for (int i = 0; i < 2; i++)
      for (int j = 3; j >= 0; j--) send_byte(words[i][8*j +: 8]);
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    check("midrst_rx_ready", 32'(rx_ready), 0);
    @(negedge clk1);
    check("midrst_hold", 32'(cpu_hold), 1);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_wc", 32'(word_count), 0);
    check("midrst_drained", exp_q.size(), 0);
    rst = 1'b0;
    @(negedge clk1);

    send_frame(9, 8'h00);
    load_random(5);
    gaps = 1;
    send_frame(5, 8'h00);

    repeat (5) @(negedge clk1);
    check("start_pulse_total", start_cnt, exp_start);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
